// File: rtl/dmem_pkg.sv
// Shared constants, FSM state encoding and access-legality decode for the data memory controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

  localparam int FUNCT3_W   = 3;
  localparam int BYTE_OFS_W = 2;
  // Wait counter holds LATENCY-2, at most 2 for LATENCY = 4.
  localparam int CNT_W      = 2;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'd0;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'd1;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'd2;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'd4;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Illegal width code or misaligned offset; range checking is done by the caller.
  function automatic logic access_err(input logic we,
                                      input logic [FUNCT3_W-1:0] funct3,
                                      input logic [BYTE_OFS_W-1:0] ofs);
    logic e;
    case (funct3)
      F3_B:    e = 1'b0;
      F3_H:    e = ofs[0];
      F3_W:    e = (ofs != 2'b00);
      F3_BU:   e = we;
      F3_HU:   e = we || ofs[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between a load-store unit and the data memory controller.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests; responses are a one-cycle strobe with no backpressure.
interface data_mem_ctrl_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [FUNCT3_W-1:0] req_funct3;
  logic [ADDR_W-1:0]   req_addr;
  logic [31:0]         req_wdata;
  logic                rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract with sign/zero extension and store byte-merge into the old word.
// Latency: purely combinational.
// Backpressure: none.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [FUNCT3_W-1:0]   funct3,
  input  logic [BYTE_OFS_W-1:0] ofs,
  input  logic [31:0]           rword,
  input  logic [31:0]           wdata,
  output logic [31:0]           ldata,
  output logic [31:0]           mword
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{ofs, 3'b000} +: 8];
  assign half_sel = rword[{ofs[1], 4'b0000} +: 16];

  // Load path: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    ldata = '0;
    case (funct3)
      F3_B:    ldata = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ldata = {{16{half_sel[15]}}, half_sel};
      F3_W:    ldata = rword;
      F3_BU:   ldata = {24'd0, byte_sel};
      F3_HU:   ldata = {16'd0, half_sel};
      default: ldata = '0;
    endcase
  end

  // Store path: overwrite only the addressed lane(s), keep the rest of the word.
  always_comb begin
    mword = rword;
    case (funct3)
      F3_B:    mword[{ofs, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    mword[{ofs[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    mword = wdata;
      default: mword = rword;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port RV32I data memory: byte/half/word loads and stores with error detection.
// Latency: response strobe LATENCY cycles after acceptance; read and store commit on the edge entering RESP.
// Backpressure: req_ready low while waiting out latency; one request per LATENCY cycles back-to-back.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 8,
  parameter int LATENCY     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_ctrl_if.slave   bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                ready_q;
  logic                cap_we;
  logic [FUNCT3_W-1:0] cap_f3;
  logic [ADDR_W-1:0]   cap_addr;
  logic [31:0]         cap_wdata;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;

  logic                accept;
  logic                enter_resp;
  logic                act_we;
  logic [FUNCT3_W-1:0] act_f3;
  logic [ADDR_W-1:0]   act_addr;
  logic [31:0]         act_wdata;
  logic [ADDR_W-3:0]   word_idx;
  logic [IDX_W-1:0]    mem_idx;
  logic                err;
  logic                mem_we;
  logic [31:0]         rword;
  logic [31:0]         ldata;
  logic [31:0]         mword;

  // Storage is deliberately outside reset: contents survive rst_n.
  logic [31:0] mem [DEPTH_WORDS];

  assign accept = bus.req_valid && ready_q;

  // Request acted on this edge: the live one for LATENCY 1, the captured one when leaving WAIT.
  always_comb begin
    act_we    = bus.req_we;
    act_f3    = bus.req_funct3;
    act_addr  = bus.req_addr;
    act_wdata = bus.req_wdata;
    if (state == ST_WAIT) begin
      act_we    = cap_we;
      act_f3    = cap_f3;
      act_addr  = cap_addr;
      act_wdata = cap_wdata;
    end
  end

  assign word_idx   = act_addr[ADDR_W-1:BYTE_OFS_W];
  assign mem_idx    = act_addr[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];
  assign err        = access_err(act_we, act_f3, act_addr[BYTE_OFS_W-1:0]) ||
                      (32'(word_idx) >= 32'(DEPTH_WORDS));
  assign enter_resp = ((state == ST_WAIT) && (cnt == '0)) || (accept && (LATENCY == 1));
  assign rword      = mem[mem_idx];
  // rst_n gate keeps a store from landing on an edge that occurs while reset is held.
  assign mem_we     = rst_n && enter_resp && act_we && !err;

  dmem_lane_align u_lane (
    .funct3 (act_f3),
    .ofs    (act_addr[BYTE_OFS_W-1:0]),
    .rword  (rword),
    .wdata  (act_wdata),
    .ldata  (ldata),
    .mword  (mword)
  );

  // Store commit into the word array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mword;
    end
  end

  // Control FSM with registered ready and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ready_q     <= 1'b1;
      cap_we      <= 1'b0;
      cap_f3      <= '0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_f3    <= bus.req_funct3;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
      end
      case (state)
        ST_WAIT: begin
          if (cnt == '0) begin
            state   <= ST_RESP;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state   <= ST_RESP;
              ready_q <= 1'b1;
            end else begin
              state   <= ST_WAIT;
              cnt     <= CNT_W'(LATENCY - 2);
              ready_q <= 1'b0;
            end
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || act_we) ? '0 : ldata;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for two controller configurations (64 words / latency 1 and 16 words / latency 3).
// Reference: byte-addressed memory arrays plus an in-order queue of expected responses with due cycles.
// Stimulus: directed sequences followed by randomized loads and stores.
module tb_data_mem_ctrl;

  localparam int LAT_A = 1;
  localparam int DEP_A = 64;
  localparam int LAT_B = 3;
  localparam int DEP_B = 16;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(8)) bus_a ();
  data_mem_ctrl_if #(.ADDR_W(8)) bus_b ();

  data_mem_ctrl #(.DEPTH_WORDS(DEP_A), .ADDR_W(8), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  data_mem_ctrl #(.DEPTH_WORDS(DEP_B), .ADDR_W(8), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mem_a [DEP_A];
  logic [31:0] mem_b [DEP_B];
  exp_t        q_a [$];
  exp_t        q_b [$];
  int          last_acc   [2];
  logic [31:0] last_rdata [2];
  logic        last_err   [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic ref_err(logic we, logic [2:0] f3, int addr, int depth);
    logic bad_code;
    int   size;
    bad_code = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size     = 1 << int'(f3[1:0]);
    return bad_code || ((addr % size) != 0) || ((addr / 4) >= depth);
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, int ofs, logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * ofs);
    case (f3)
      3'd0:    return ((v & 32'hFF) ^ 32'h80) - 32'h80;
      3'd1:    return ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd2:    return word;
      3'd4:    return v & 32'hFF;
      3'd5:    return v & 32'hFFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(logic [2:0] f3, int ofs, logic [31:0] word, logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    return (word & ~(mask << (8 * ofs))) | ((wd & mask) << (8 * ofs));
  endfunction

  task automatic drv(int sel, logic v, logic we, logic [2:0] f3, logic [7:0] addr, logic [31:0] wd);
    if (sel == 0) begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_funct3 = f3;
      bus_a.req_addr = addr; bus_a.req_wdata = wd;
    end else begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_funct3 = f3;
      bus_b.req_addr = addr; bus_b.req_wdata = wd;
    end
  endtask

  function automatic logic rdy(int sel);
    return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction

  function automatic int qsize(int s);
    return (s == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic int qdue(int s);
    return (s == 0) ? q_a[0].due : q_b[0].due;
  endfunction

  task automatic qpop(int s, output exp_t x);
    if (s == 0) x = q_a.pop_front();
    else        x = q_b.pop_front();
  endtask

  // Model of one accepted request: memory effect now, response due LATENCY edges later.
  task automatic model_accept(int sel, logic we, logic [2:0] f3, logic [7:0] addr, logic [31:0] wd, int acc);
    exp_t        e;
    int          idx, ofs, depth, lat;
    logic [31:0] word;
    depth  = (sel == 0) ? DEP_A : DEP_B;
    lat    = (sel == 0) ? LAT_A : LAT_B;
    idx    = int'(addr) / 4;
    ofs    = int'(addr) % 4;
    e.err  = ref_err(we, f3, int'(addr), depth);
    word   = 32'h0;
    if (!e.err) word = (sel == 0) ? mem_a[idx] : mem_b[idx];
    e.rdata = (e.err || we) ? 32'h0 : ref_load(f3, ofs, word);
    if (!e.err && we) begin
      if (sel == 0) mem_a[idx] = ref_store(f3, ofs, word, wd);
      else          mem_b[idx] = ref_store(f3, ofs, word, wd);
    end
    e.due = acc + lat - 1;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    last_acc[sel] = acc;
  endtask

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic send(int sel, logic we, logic [2:0] f3, logic [7:0] addr, logic [31:0] wd, bit abandon);
    int budget = 50;
    drv(sel, 1'b1, we, f3, addr, wd);
    while (!rdy(sel) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      chk("ready_timeout", 32'(rdy(sel)), 32'd1);
      drv(sel, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
      return;
    end
    if (abandon) last_acc[sel] = cyc + 1;
    else         model_accept(sel, we, f3, addr, wd, cyc + 1);
    @(negedge clk);
    drv(sel, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
  endtask

  task automatic drain(int sel);
    int budget = 20;
    while (qsize(sel) > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (qsize(sel) > 0) chk("drain_timeout", 32'(qsize(sel)), 32'd0);
  endtask

  task automatic xact(int sel, logic we, logic [2:0] f3, logic [7:0] addr, logic [31:0] wd);
    send(sel, we, f3, addr, wd, 1'b0);
    drain(sel);
  endtask

  task automatic mon(int s);
    logic        v, e, r, rexp;
    logic [31:0] d;
    exp_t        x;
    string       p;
    int          lat;
    p   = (s == 0) ? "a_" : "b_";
    lat = (s == 0) ? LAT_A : LAT_B;
    if (s == 0) begin v = bus_a.rsp_valid; e = bus_a.rsp_err; r = bus_a.req_ready; d = bus_a.rsp_rdata; end
    else        begin v = bus_b.rsp_valid; e = bus_b.rsp_err; r = bus_b.req_ready; d = bus_b.rsp_rdata; end
    if (!rst_n) begin
      chk({p, "rst_ready"}, 32'(r), 32'd1);
      chk({p, "rst_valid"}, 32'(v), 32'd0);
      chk({p, "rst_rdata"}, d, 32'd0);
      chk({p, "rst_err"}, 32'(e), 32'd0);
      return;
    end
    while (qsize(s) > 0 && qdue(s) < cyc) begin
      qpop(s, x);
      chk({p, "rsp_missing_due"}, 32'(cyc), 32'(x.due));
    end
    rexp = !(cyc >= last_acc[s] && cyc <= last_acc[s] + lat - 2);
    chk({p, "ready"}, 32'(r), 32'(rexp));
    if (v) begin
      if (qsize(s) == 0) begin
        chk({p, "rsp_spurious"}, 32'(v), 32'd0);
      end else begin
        qpop(s, x);
        chk({p, "rsp_cycle"}, 32'(cyc), 32'(x.due));
        chk({p, "rsp_rdata"}, d, x.rdata);
        chk({p, "rsp_err"}, 32'(e), 32'(x.err));
        last_rdata[s] = d;
        last_err[s]   = e;
      end
    end else begin
      chk({p, "idle_rdata"}, d, 32'd0);
      chk({p, "idle_err"}, 32'(e), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic do_reset(int n);
    #2;
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    last_acc[0] = -1000;
    last_acc[1] = -1000;
    repeat (n) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic directed(int sel);
    string p;
    p = (sel == 0) ? "a_" : "b_";
    xact(sel, 1'b1, 3'd2, 8'h10, 32'hDEADBEEF);
    chk({p, "sw_err"}, 32'(last_err[sel]), 32'd0);
    xact(sel, 1'b0, 3'd2, 8'h10, 32'd0);
    chk({p, "lw_deadbeef"}, last_rdata[sel], 32'hDEADBEEF);
    chk({p, "lw_err"}, 32'(last_err[sel]), 32'd0);
    xact(sel, 1'b1, 3'd0, 8'h13, 32'h00000080);
    xact(sel, 1'b0, 3'd0, 8'h13, 32'd0);
    chk({p, "lb_sext"}, last_rdata[sel], 32'hFFFFFF80);
    xact(sel, 1'b0, 3'd4, 8'h13, 32'd0);
    chk({p, "lbu_zext"}, last_rdata[sel], 32'h00000080);
    xact(sel, 1'b0, 3'd2, 8'h10, 32'd0);
    chk({p, "lw_merged"}, last_rdata[sel], 32'h80ADBEEF);
    xact(sel, 1'b0, 3'd1, 8'h11, 32'd0);
    chk({p, "lh_misalign_err"}, 32'(last_err[sel]), 32'd1);
    chk({p, "lh_misalign_rdata"}, last_rdata[sel], 32'd0);
    xact(sel, 1'b1, 3'd2, 8'h12, 32'h12345678);
    chk({p, "sw_misalign_err"}, 32'(last_err[sel]), 32'd1);
    xact(sel, 1'b0, 3'd3, 8'h10, 32'd0);
    chk({p, "f3_illegal_err"}, 32'(last_err[sel]), 32'd1);
    chk({p, "f3_illegal_rdata"}, last_rdata[sel], 32'd0);
    xact(sel, 1'b0, 3'd2, 8'h10, 32'd0);
    chk({p, "lw_unchanged"}, last_rdata[sel], 32'h80ADBEEF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [2:0] f3;
    logic [7:0] addr;
    logic       we;
    int         sel;

    drv(0, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    last_acc[0] = -1000;
    last_acc[1] = -1000;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    // Give every word a known value in both the DUTs and the model.
    for (int w = 0; w < DEP_A; w++) send(0, 1'b1, 3'd2, 8'(w * 4), $urandom, 1'b0);
    drain(0);
    for (int w = 0; w < DEP_B; w++) send(1, 1'b1, 3'd2, 8'(w * 4), $urandom, 1'b0);
    drain(1);

    directed(0);
    directed(1);

    // Word-index range boundary.
    xact(1, 1'b0, 3'd2, 8'h40, 32'd0);
    chk("b_lw_0x40_err", 32'(last_err[1]), 32'd1);
    xact(1, 1'b0, 3'd2, 8'h3C, 32'd0);
    chk("b_lw_0x3c_err", 32'(last_err[1]), 32'd0);
    xact(0, 1'b0, 3'd2, 8'h40, 32'd0);
    chk("a_lw_0x40_err", 32'(last_err[0]), 32'd0);

    // Valid held high across four back-to-back requests.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) send(s, 1'(i % 2), 3'd2, 8'(8'h20 + 4 * (i / 2)), $urandom, 1'b0);
      drain(s);
    end

    // Store abandoned by reset while waiting must not land.
    xact(1, 1'b1, 3'd2, 8'h24, 32'h11223344);
    send(1, 1'b1, 3'd2, 8'h24, 32'hAAAAAAAA, 1'b1);
    do_reset(2);
    xact(1, 1'b0, 3'd2, 8'h24, 32'd0);
    chk("b_reset_store_dropped", last_rdata[1], 32'h11223344);

    // Randomized traffic across both configurations.
    repeat (400) begin
      sel  = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = (sel == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 71));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      send(sel, we, f3, addr, $urandom, 1'b0);
    end
    drain(0);
    drain(1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit storage words.
REQ-002 SHALL have parameter ADDR_W, default 8: byte-address width; SHALL satisfy 2^(ADDR_W-2) >= DEPTH_WORDS.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 1..4: cycles from request acceptance to response.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1: a request is presented.
REQ-007 SHALL have port req_ready, output, 1: the block can accept a request this cycle.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3, input, 3: RV32I width/sign code.
REQ-010 SHALL have port req_addr, input, ADDR_W: byte address.
REQ-011 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1: one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1: request was rejected (misaligned, illegal funct3, or out of range); valid only with rsp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 in IDLE and RESP, 0 in WAIT.
REQ-016 SHALL accept a request on any rising edge where req_valid && req_ready, capturing we, funct3, addr and wdata.
REQ-017 On acceptance SHALL go to RESP if LATENCY == 1, otherwise to WAIT with the counter loaded to LATENCY-2; WAIT SHALL decrement the counter and go to RESP when it reaches 0.
REQ-018 rsp_valid SHALL be 1 exactly in RESP, i.e. for exactly one cycle, LATENCY edges after acceptance; there is no response backpressure.
REQ-019 In RESP without a new acceptance, the FSM SHALL return to IDLE; with a new acceptance it SHALL follow REQ-017 (back-to-back throughput of one request per LATENCY cycles).
REQ-020 Loads SHALL support LB(0), LH(1), LW(2), LBU(4), LHU(5), selecting lanes by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-021 Stores SHALL support SB(0), SH(1), SW(2), updating only the addressed byte lanes, with all other bytes of the word preserved.
REQ-022 Errors: halfword access with addr[0] = 1; word access with addr[1:0] != 0; load funct3 in {3,6,7}; store funct3 > 2; word index addr[ADDR_W-1:2] >= DEPTH_WORDS.
REQ-023 On error the block SHALL NOT write memory, and SHALL drive rsp_err = 1 and rsp_rdata = 0.
REQ-024 The memory read and the store commit SHALL both happen on the edge entering RESP; a load directly after a store to the same word SHALL return the updated data.
REQ-025 Outside RESP, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-026 While rst_n = 0: state = IDLE, counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and the captured request is cleared.
REQ-027 Reset asserted mid-operation SHALL abandon the pending request with no response; a store not yet committed SHALL NOT be written.
REQ-028 Reset SHALL NOT clear storage contents; simulation SHALL initialise all words to 0.

Structure
REQ-029 Package dmem_pkg SHALL hold the funct3 constants, the FSM state enum, and the error-decode width constants.
REQ-030 Lane logic (load extract/extend, store byte-merge) SHALL live in one combinational sub-module, dmem_lane_align; the FSM and storage stay in data_mem_ctrl.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, with each rsp_valid exactly LATENCY cycles after acceptance.
REQ-032 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-033 LH @0x11, SW @0x12 and LW with funct3 = 3 -> rsp_err = 1 and rsp_rdata = 0; a following LW @0x10 shows the word unchanged.
REQ-034 With DEPTH_WORDS = 16: LW @0x40 -> rsp_err = 1; LW @0x3C -> rsp_err = 0.
REQ-035 LATENCY = 3 with req_valid held high for 4 requests -> req_ready low during WAIT, 4 responses spaced 3 cycles apart.
REQ-036 SW accepted, then rst_n pulsed low before RESP -> no rsp_valid, and a later LW of that address returns the old value.
